// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU control sequencer: control codes,
// ALUOp and Funct7 encodings, FSM state type and the base-op lookup.
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_MUL  = 4'b1010;
  localparam logic [3:0] C_MULH = 4'b1011;
  localparam logic [3:0] C_DIV  = 4'b1100;
  localparam logic [3:0] C_DIVU = 4'b1101;
  localparam logic [3:0] C_REM  = 4'b1110;
  localparam logic [3:0] C_REMU = 4'b1111;

  // ALUOp encodings from instruction decode
  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ITYPE  = 2'b11;

  // Funct7 values recognised for R-type
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // Upper six Funct7 bits for I-type shifts (bit 0 is shamt[5] on RV64)
  localparam logic [5:0] F7HI_LOGIC = 6'b000000;
  localparam logic [5:0] F7HI_ARITH = 6'b010000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Funct3 to control code for the Funct7=BASE group (shared by R and I type)
  function automatic logic [3:0] base_code(input logic [2:0] funct3);
    logic [3:0] code;
    case (funct3)
      3'b000:  code = C_ADD;
      3'b001:  code = C_SLL;
      3'b010:  code = C_SLT;
      3'b011:  code = C_SLTU;
      3'b100:  code = C_XOR;
      3'b101:  code = C_SRL;
      3'b110:  code = C_OR;
      default: code = C_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decoder: ALUOp/Funct7/Funct3 to control code,
// plus illegal, multi-cycle and divide-class flags for the sequencer.
module alu_decode
  import alu_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [1:0] aluop,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] code,
  output logic       illegal,
  output logic       multi,
  output logic       isdiv
);

  // Decode the operation; any illegal combination collapses to a plain add
  always_comb begin
    code    = C_ADD;
    illegal = 1'b0;
    multi   = 1'b0;
    isdiv   = 1'b0;
    case (aluop)
      OP_MEM:    code = C_ADD;
      OP_BRANCH: code = C_SUB;
      OP_RTYPE: begin
        case (funct7)
          F7_BASE: code = base_code(funct3);
          F7_ALT: begin
            case (funct3)
              3'b000:  code = C_SUB;
              3'b101:  code = C_SRA;
              default: illegal = 1'b1;
            endcase
          end
          F7_MEXT: begin
            if (M_EXT != 0) begin
              multi = 1'b1;
              isdiv = funct3[2];
              case (funct3)
                3'b000:  code = C_MUL;
                3'b001:  code = C_MULH;
                3'b100:  code = C_DIV;
                3'b101:  code = C_DIVU;
                3'b110:  code = C_REM;
                3'b111:  code = C_REMU;
                default: illegal = 1'b1;
              endcase
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        // I-type: only the shifts constrain Funct7
        case (funct3)
          3'b001: begin
            if (funct7[6:1] == F7HI_LOGIC) code = C_SLL;
            else                           illegal = 1'b1;
          end
          3'b101: begin
            if (funct7[6:1] == F7HI_LOGIC)      code = C_SRL;
            else if (funct7[6:1] == F7HI_ARITH) code = C_SRA;
            else                                illegal = 1'b1;
          end
          default: code = base_code(funct3);
        endcase
      end
    endcase
    if (illegal) begin
      code  = C_ADD;
      multi = 1'b0;
      isdiv = 1'b0;
    end
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control sequencer. Single-cycle ops return
// OutValid one cycle after accept; M ops hold the block busy for their
// configured latency using a down-counter.
module alu_control_seq
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int M_EXT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       InValid,
  output logic       InReady,
  input  logic [1:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       Flush,
  output logic       OutValid,
  output logic [3:0] Outputs,
  output logic       MultiCycle,
  output logic       Busy,
  output logic       Illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [3:0]       dec_code;
  logic             dec_illegal;
  logic             dec_multi;
  logic             dec_isdiv;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] lat_load;
  logic [3:0]       outputs_nx;
  logic             illegal_nx;
  logic             multi_nx;
  logic             busy_nx;
  logic             ovalid_nx;
  logic             accept;

  alu_decode #(.M_EXT(M_EXT)) u_decode (
    .aluop   (ALUOp),
    .funct7  (Funct7),
    .funct3  (Funct3),
    .code    (dec_code),
    .illegal (dec_illegal),
    .multi   (dec_multi),
    .isdiv   (dec_isdiv)
  );

  assign InReady  = (state == S_IDLE);
  assign accept   = InValid & InReady & ~Flush;
  assign lat_load = dec_isdiv ? DIV_LOAD : MUL_LOAD;

  // Next-state and next-register values; Flush overrides everything but the result fields
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    outputs_nx = Outputs;
    illegal_nx = Illegal;
    multi_nx   = MultiCycle;
    busy_nx    = Busy;
    ovalid_nx  = 1'b0;
    if (Flush) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      busy_nx  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            outputs_nx = dec_code;
            illegal_nx = dec_illegal;
            multi_nx   = dec_multi;
            if (dec_multi && (lat_load != '0)) begin
              cnt_nx   = lat_load;
              busy_nx  = 1'b1;
              state_nx = S_WAIT;
            end else begin
              ovalid_nx = 1'b1;
            end
          end
        end
        default: begin
          // The <= guard keeps a corrupted zero count from wrapping
          if (cnt <= ONE) begin
            cnt_nx    = '0;
            ovalid_nx = 1'b1;
            busy_nx   = 1'b0;
            state_nx  = S_IDLE;
          end else begin
            cnt_nx = cnt - ONE;
          end
        end
      endcase
    end
  end

  // State, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      Outputs    <= C_ADD;
      Illegal    <= 1'b0;
      MultiCycle <= 1'b0;
      Busy       <= 1'b0;
      OutValid   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      Outputs    <= outputs_nx;
      Illegal    <= illegal_nx;
      MultiCycle <= multi_nx;
      Busy       <= busy_nx;
      OutValid   <= ovalid_nx;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: three configurations driven in parallel
// against a timeline model (accept cycle + latency), plus directed cases.
module tb_alu_control_seq;

  logic       clk;
  logic       rst_n;
  logic       InValid;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       Flush;

  logic       rdy  [3];
  logic       ov   [3];
  logic [3:0] outc [3];
  logic       mc   [3];
  logic       busy [3];
  logic       ill  [3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Per-instance configuration mirrored from the instance parameters below
  bit mext_p [3] = '{1'b1, 1'b0, 1'b1};
  int mul_p  [3] = '{3, 3, 1};
  int div_p  [3] = '{33, 33, 2};

  alu_control_seq #(.MUL_LAT(3), .DIV_LAT(33), .M_EXT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(rdy[0]),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .Flush(Flush),
    .OutValid(ov[0]), .Outputs(outc[0]), .MultiCycle(mc[0]),
    .Busy(busy[0]), .Illegal(ill[0])
  );

  alu_control_seq #(.MUL_LAT(3), .DIV_LAT(33), .M_EXT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(rdy[1]),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .Flush(Flush),
    .OutValid(ov[1]), .Outputs(outc[1]), .MultiCycle(mc[1]),
    .Busy(busy[1]), .Illegal(ill[1])
  );

  alu_control_seq #(.MUL_LAT(1), .DIV_LAT(2), .M_EXT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(rdy[2]),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .Flush(Flush),
    .OutValid(ov[2]), .Outputs(outc[2]), .MultiCycle(mc[2]),
    .Busy(busy[2]), .Illegal(ill[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference decode from the operation tables
  function automatic void ref_dec(input bit mext, input logic [1:0] op, input logic [6:0] f7,
                                  input logic [2:0] f3, output logic [3:0] code,
                                  output bit illg, output bit multi, output bit dv);
    logic [3:0] base_t [8] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};
    logic [3:0] m_t    [8] = '{4'hA, 4'hB, 4'h0, 4'h0, 4'hC, 4'hD, 4'hE, 4'hF};
    code = 4'h2; illg = 0; multi = 0; dv = 0;
    if (op == 2'b00) code = 4'h2;
    else if (op == 2'b01) code = 4'h6;
    else if (op == 2'b10) begin
      if (f7 == 7'h00) code = base_t[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 4'h6;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 4'h7;
      else if (f7 == 7'h01 && mext && f3 != 3'd2 && f3 != 3'd3) begin
        code = m_t[f3]; multi = 1; dv = (f3 >= 3'd4);
      end else illg = 1;
    end else begin
      if (f3 != 3'd1 && f3 != 3'd5) code = base_t[f3];
      else if (f7[6:1] == 6'd0) code = base_t[f3];
      else if (f3 == 3'd5 && f7[6:1] == 6'b010000) code = 4'h7;
      else illg = 1;
    end
    if (illg) code = 4'h2;
  endfunction

  // Timeline model: each accept schedules OutValid at accept_edge + latency - 1
  int         cyc = 0;
  int         done_at [3] = '{-1, -1, -1};
  logic [3:0] e_code [3] = '{4'h2, 4'h2, 4'h2};
  bit         e_ill  [3];
  bit         e_mc   [3];
  bit         e_ov   [3];
  bit         e_busy [3];

  initial begin : model
    logic [3:0] c;
    bit il, m, dv;
    int lat;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) begin
          done_at[i] = -1; e_code[i] = 4'h2; e_ill[i] = 0; e_mc[i] = 0;
          e_ov[i] = 0; e_busy[i] = 0;
        end
      end else begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
          if (Flush) done_at[i] = -1;
          else if (InValid && (cyc - 1 >= done_at[i])) begin
            ref_dec(mext_p[i], ALUOp, Funct7, Funct3, c, il, m, dv);
            e_code[i] = c; e_ill[i] = il; e_mc[i] = m;
            lat = m ? (dv ? div_p[i] : mul_p[i]) : 1;
            done_at[i] = cyc + lat - 1;
          end
          e_ov[i]   = (done_at[i] == cyc);
          e_busy[i] = (done_at[i] > cyc);
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge
  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("OutValid[%0d]", i),   ov[i],   e_ov[i]);
          chk($sformatf("Busy[%0d]", i),       busy[i], e_busy[i]);
          chk($sformatf("InReady[%0d]", i),    rdy[i],  !e_busy[i]);
          chk($sformatf("Outputs[%0d]", i),    outc[i], e_code[i]);
          chk($sformatf("Illegal[%0d]", i),    ill[i],  e_ill[i]);
          chk($sformatf("MultiCycle[%0d]", i), mc[i],   e_mc[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    InValid = v; ALUOp = op; Funct7 = f7; Funct3 = f3;
  endtask

  initial begin : stim
    int r;
    rst_n = 1'b1; InValid = 0; ALUOp = 0; Funct7 = 0; Funct3 = 0; Flush = 0;
    #2 rst_n = 1'b0;
    #1 cmp_en = 1;
    repeat (3) step();
    chk("rst_Outputs", outc[0], 4'b0010);
    chk("rst_OutValid", ov[0], 1'b0);
    chk("rst_Busy", busy[0], 1'b0);
    chk("rst_InReady", rdy[0], 1'b1);
    rst_n = 1'b1;
    step();

    // Back-to-back single-cycle ops
    set_op(1, 2'b10, 7'b0100000, 3'b000); step();
    chk("sub_ov", ov[0], 1'b1); chk("sub_code", outc[0], 4'b0110);
    set_op(1, 2'b10, 7'b0000000, 3'b110); step();
    chk("or_ov", ov[0], 1'b1); chk("or_code", outc[0], 4'b0001);
    set_op(1, 2'b11, 7'b0100000, 3'b101); step();
    chk("srai_code", outc[0], 4'b0111);
    set_op(1, 2'b11, 7'b0100000, 3'b001); step();
    chk("slli_ill", ill[0], 1'b1); chk("slli_code", outc[0], 4'b0010);
    chk("slli_ov", ov[0], 1'b1);

    // Divide, 33-cycle latency on dut0; illegal single-cycle on dut1
    set_op(1, 2'b10, 7'b0000001, 3'b100); step();
    set_op(0, 2'b00, 7'b0, 3'b0);
    chk("div_m0_ill", ill[1], 1'b1); chk("div_m0_ov", ov[1], 1'b1);
    chk("div_busy", busy[0], 1'b1); chk("div_rdy", rdy[0], 1'b0);
    for (int k = 0; k < 31; k++) begin
      step();
      chk("div_busy_hold", busy[0], 1'b1); chk("div_no_ov", ov[0], 1'b0);
    end
    step();
    chk("div_ov", ov[0], 1'b1); chk("div_code", outc[0], 4'b1100);
    chk("div_mc", mc[0], 1'b1); chk("div_rdy_done", rdy[0], 1'b1);
    step();
    chk("div_single_pulse", ov[0], 1'b0);

    // Flush on cycle 2 of a multiply
    set_op(1, 2'b10, 7'b0000001, 3'b000); step();
    set_op(0, 2'b00, 7'b0, 3'b0);
    chk("mul_m0_ill", ill[1], 1'b1); chk("mul_m0_ov", ov[1], 1'b1);
    step();
    Flush = 1; step(); Flush = 0;
    chk("flush_ov", ov[0], 1'b0); chk("flush_busy", busy[0], 1'b0);
    chk("flush_rdy", rdy[0], 1'b1);
    step();
    chk("flush_no_late_ov", ov[0], 1'b0);

    // Asynchronous reset mid-divide
    set_op(1, 2'b10, 7'b0000001, 3'b101); step();
    set_op(0, 2'b00, 7'b0, 3'b0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy[0], 1'b0); chk("arst_ov", ov[0], 1'b0);
    chk("arst_code", outc[0], 4'b0010); chk("arst_rdy", rdy[0], 1'b1);
    chk("arst_mc", mc[0], 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_no_ov", ov[0], 1'b0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      InValid = ($urandom_range(0, 3) != 0);
      ALUOp   = 2'($urandom_range(0, 3));
      Funct3  = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 5);
      case (r)
        0: Funct7 = 7'h00;
        1: Funct7 = 7'h20;
        2: Funct7 = 7'h01;
        3: Funct7 = 7'h21;
        4: Funct7 = 7'h01;
        default: Funct7 = 7'($urandom_range(0, 127));
      endcase
      Flush = ($urandom_range(0, 24) == 0);
      step();
    end
    Flush = 0; InValid = 0;
    step();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, handshaked successor to the combinational ALU control decoder for the RiskV datapath, sitting between instruction decode and the execute stage. It decodes ALUOp/Funct7/Funct3 into a 4-bit ALU control code. Beyond the original add/sub/and/or set, it covers the full RV64I ALU set and, optionally, M-extension multiply/divide. For multi-cycle M operations it sequences the execute unit with a latency counter and valid/ready handshake.

## Interface
- MUL_LAT, 3, cycles from accept to OutValid for mul/mulh; ≥1
- DIV_LAT, 33, cycles from accept to OutValid for div/divu/rem/remu; ≥1
- M_EXT, 1, 1 = decode Funct7=0000001 as M ops; 0 = flag them Illegal
- CNT_W (localparam), $clog2(max(MUL_LAT,DIV_LAT)+1), latency counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- InValid  in  1  decode presents an operation
- InReady  out  1  block can accept; combinational, =1 exactly in IDLE
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- Funct7  in  7  instruction funct7 (bits 31:25)
- Funct3  in  3  instruction funct3
- Flush  in  1  synchronous pipeline flush
- OutValid  out  1  one-cycle pulse: Outputs/Illegal result complete
- Outputs  out  4  registered ALU control code
- MultiCycle  out  1  registered; current op is an M op
- Busy  out  1  registered; in WAIT
- Illegal  out  1  registered; undecodable combination

## Operation
- Codes: and 0000, or 0001, add 0010, xor 0011, sll 0100, srl 0101, sub 0110, sra 0111, slt 1000, sltu 1001, mul 1010, mulh 1011, div 1100, divu 1101, rem 1110, remu 1111.
- ALUOp 00 -> add, 01 -> sub; Funct7/Funct3 ignored.
- ALUOp 10:
  - Funct7 0000000: Funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
  - Funct7 0100000: 000 sub, 101 sra; other Funct3 illegal.
  - Funct7 0000001 (M_EXT=1): 000 mul, 001 mulh, 100 div, 101 divu, 110 rem, 111 remu; 010/011 illegal.
  - Any other Funct7 illegal.
- ALUOp 11:
  - Funct7 ignored for 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - 001 sll only if Funct7[6:1]=000000.
  - 101: srl if Funct7[6:1]=000000, sra if 010000.
  - Any other Funct7/Funct3 combination illegal.
- Illegal op: Outputs=0010, Illegal=1, MultiCycle=0; handled as single-cycle.
- FSM states IDLE, WAIT.
  - IDLE, accept (InValid&InReady&!Flush): register Outputs/Illegal/MultiCycle.
    - Non-M, or M with LAT=1: OutValid=1 next cycle, stay IDLE.
    - M with LAT>1: counter<=LAT-1, Busy<=1, ->WAIT.
  - WAIT: InReady=0; Outputs/MultiCycle held stable; counter decrements each cycle. When counter==1: OutValid<=1, Busy<=0, ->IDLE.
- Flush: next edge forces IDLE; OutValid=0, Busy=0, counter=0; Outputs retains value. Flush with InValid in IDLE: op not accepted.

## Timing
- Reset values: Outputs=0010, OutValid=0, MultiCycle=0, Busy=0, Illegal=0, state IDLE, counter 0; InReady=1.
- Single-cycle latency 1: accept at edge N, OutValid high cycle N+1; back-to-back accepts give OutValid every cycle.
- M latency exactly MUL_LAT/DIV_LAT cycles accept-to-OutValid; InReady=1 in the OutValid cycle, so a new op may be accepted then.
- OutValid is never high for two cycles for the same op; never high after Flush until a new accept.
- rst_n assertion mid-WAIT: immediate return to reset values; no OutValid.
- Counter never wraps; loaded only on accept.

## Structure
- Package alu_pkg: 4-bit control code constants, ALUOp encodings, Funct7 constants (BASE 0000000, ALT 0100000, MEXT 0000001), state enum.
- Sub-module alu_decode: combinational {Outputs, Illegal, MultiCycle, IsDiv} from ALUOp/Funct7/Funct3/M_EXT. The sequencer holds the FSM, counter and registers.

## Test plan
- Reset: rst_n=0 -> Outputs=0010, OutValid=0, Busy=0, InReady=1.
- ALUOp=10, Funct7=0100000, Funct3=000 accepted -> next cycle OutValid=1, Outputs=0110; then ALUOp=10, Funct7=0000000, Funct3=110 back-to-back -> Outputs=0001 next cycle.
- ALUOp=11, Funct7=0100000, Funct3=101 -> 0111. ALUOp=11, Funct7=0100000, Funct3=001 -> Illegal=1, Outputs=0010.
- ALUOp=10, Funct7=0000001, Funct3=100 with DIV_LAT=33 -> Busy/InReady=0 for 32 cycles, OutValid at cycle 33, Outputs=1100, MultiCycle=1.
- Flush at cycle 2 of a mul (MUL_LAT=3) -> no OutValid, Busy=0, InReady=1 next cycle; rst_n pulse mid-div -> same.
- M_EXT=0: Funct7=0000001, Funct3=000 -> Illegal=1, single-cycle OutValid.
